// File: rtl/sram_like_burst_bridge.sv
// SRAM-style pipeline access -> SRAM-like handshake bridge.
// Reads fetch an aligned block of WORDS words into a line buffer, one
// outstanding transaction at a time. Writes issue a single beat whose size
// and low address bits come from the byte enables. Bus-side outputs are
// registered, so they have no combinational path from cpu_*.
module sram_like_burst_bridge #(
  parameter int ADDR_W      = 32,
  parameter int WORDS       = 4,
  parameter int ALLOW_WRITE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpu_en,
  input  logic [ADDR_W-1:0]    cpu_addr,
  input  logic [3:0]           cpu_wen,
  input  logic [31:0]          cpu_wdata,
  output logic [32*WORDS-1:0]  cpu_rdata,
  output logic                 cpu_stall,
  input  logic                 all_stall,
  output logic                 req,
  output logic                 wr,
  output logic [1:0]           size,
  output logic [ADDR_W-1:0]    addr,
  output logic [31:0]          wdata,
  input  logic                 addr_ok,
  input  logic                 data_ok,
  input  logic [31:0]          rdata
);

  localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int OFF_W = $clog2(4 * WORDS);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [32*WORDS-1:0] line;

  logic                acc_wr;
  logic [1:0]          acc_size;
  logic [1:0]          acc_lo;
  logic [ADDR_W-1:0]   acc_addr;
  logic                beat;
  logic                last;

  assign cpu_rdata = line;
  assign cpu_stall = cpu_en & (state != DONE);

  // A beat completes on data_ok in DATA, or on addr_ok+data_ok together in ADDR.
  // wr doubles as the latched "this access is a write" flag.
  assign beat = ((state == ADDR) && addr_ok && data_ok) || ((state == DATA) && data_ok);
  assign last = wr || (cnt == CW'(WORDS - 1));

  // Decode the incoming access; only consumed when it is latched in IDLE.
  always_comb begin
    acc_wr   = (ALLOW_WRITE != 0) && (cpu_wen != 4'b0000);
    acc_size = 2'd2;
    acc_lo   = 2'b00;
    case (cpu_wen)
      4'b0011: begin acc_size = 2'd1; acc_lo = 2'b00; end
      4'b1100: begin acc_size = 2'd1; acc_lo = 2'b10; end
      4'b0001: begin acc_size = 2'd0; acc_lo = 2'b00; end
      4'b0010: begin acc_size = 2'd0; acc_lo = 2'b01; end
      4'b0100: begin acc_size = 2'd0; acc_lo = 2'b10; end
      4'b1000: begin acc_size = 2'd0; acc_lo = 2'b11; end
      default: begin acc_size = 2'd2; acc_lo = 2'b00; end
    endcase
    if (acc_wr) begin
      acc_addr = {cpu_addr[ADDR_W-1:2], acc_lo};
    end else begin
      acc_size = 2'd2;
      acc_addr = {cpu_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    end
  end

  // Handshake FSM with registered bus outputs and the read line buffer.
  // A completed beat overrides the per-state transition below it; the next
  // read address is the previous one + 4, i.e. aligned base + 4*cnt.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      line  <= '0;
      req   <= 1'b0;
      wr    <= 1'b0;
      size  <= 2'd2;
      addr  <= '0;
      wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_en) begin
            state <= ADDR;
            cnt   <= '0;
            req   <= 1'b1;
            wr    <= acc_wr;
            size  <= acc_size;
            addr  <= acc_addr;
            wdata <= cpu_wdata;
          end
        end
        ADDR: begin
          if (addr_ok && !data_ok) begin
            req   <= 1'b0;
            state <= DATA;
          end
        end
        DATA: ;
        DONE: begin
          if (!all_stall) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (beat) begin
        if (!wr) begin
          for (int i = 0; i < WORDS; i++) begin
            if (cnt == CW'(i)) line[32*i +: 32] <= rdata;
          end
        end
        if (last) begin
          state <= DONE;
          req   <= 1'b0;
        end else begin
          cnt   <= cnt + CW'(1);
          state <= ADDR;
          req   <= 1'b1;
          addr  <= addr + ADDR_W'(4);
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_like_burst_bridge.sv
// Directed bench for sram_like_burst_bridge: three instances share stimulus
// (4-word read/write, 1-word data port, 4-word read-only); each test checks
// one instance after a reset.
module tb_sram_like_burst_bridge;

  logic        clk = 1'b0;
  logic        rst, cpu_en, all_stall, addr_ok, data_ok;
  logic [31:0] cpu_addr, cpu_wdata, rdata;
  logic [3:0]  cpu_wen;

  logic [127:0] r4, r0;
  logic [31:0]  r1;
  logic         st4, st1, st0, req4, req1, req0, wr4, wr1, wr0;
  logic [1:0]   sz4, sz1, sz0;
  logic [31:0]  ad4, ad1, ad0, wd4, wd1, wd0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sram_like_burst_bridge #(.ADDR_W(32), .WORDS(4), .ALLOW_WRITE(1)) u4 (
    .clk(clk), .rst(rst), .cpu_en(cpu_en), .cpu_addr(cpu_addr), .cpu_wen(cpu_wen),
    .cpu_wdata(cpu_wdata), .cpu_rdata(r4), .cpu_stall(st4), .all_stall(all_stall),
    .req(req4), .wr(wr4), .size(sz4), .addr(ad4), .wdata(wd4),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata));

  sram_like_burst_bridge #(.ADDR_W(32), .WORDS(1), .ALLOW_WRITE(1)) u1 (
    .clk(clk), .rst(rst), .cpu_en(cpu_en), .cpu_addr(cpu_addr), .cpu_wen(cpu_wen),
    .cpu_wdata(cpu_wdata), .cpu_rdata(r1), .cpu_stall(st1), .all_stall(all_stall),
    .req(req1), .wr(wr1), .size(sz1), .addr(ad1), .wdata(wd1),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata));

  sram_like_burst_bridge #(.ADDR_W(32), .WORDS(4), .ALLOW_WRITE(0)) u0 (
    .clk(clk), .rst(rst), .cpu_en(cpu_en), .cpu_addr(cpu_addr), .cpu_wen(cpu_wen),
    .cpu_wdata(cpu_wdata), .cpu_rdata(r0), .cpu_stall(st0), .all_stall(all_stall),
    .req(req0), .wr(wr0), .size(sz0), .addr(ad0), .wdata(wd0),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata));

  typedef struct {
    logic [3:0]  wen;
    logic [31:0] a;
    logic [31:0] wd;
    logic [1:0]  sz;
    logic [31:0] ea;
  } wvec_t;

  wvec_t tbl [7];
  logic [31:0] words [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; cpu_en = 1'b0; cpu_addr = '0; cpu_wen = '0; cpu_wdata = '0;
    all_stall = 1'b0; addr_ok = 1'b0; data_ok = 1'b0; rdata = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    tbl[0] = '{4'b0100, 32'h8000_0003, 32'h1111_1111, 2'd0, 32'h8000_0002};
    tbl[1] = '{4'b1100, 32'h8000_0001, 32'h2222_2222, 2'd1, 32'h8000_0002};
    tbl[2] = '{4'b1111, 32'h8000_0003, 32'h3333_3333, 2'd2, 32'h8000_0000};
    tbl[3] = '{4'b0011, 32'h8000_0002, 32'h4444_4444, 2'd1, 32'h8000_0000};
    tbl[4] = '{4'b1000, 32'h8000_0000, 32'h5555_5555, 2'd0, 32'h8000_0003};
    tbl[5] = '{4'b0001, 32'h8000_0002, 32'h6666_6666, 2'd0, 32'h8000_0000};
    tbl[6] = '{4'b0101, 32'h8000_0001, 32'h7777_7777, 2'd2, 32'h8000_0000};
    words[0] = 32'hAAAA_0000; words[1] = 32'hBBBB_1111;
    words[2] = 32'hCCCC_2222; words[3] = 32'hDDDD_3333;

    // reset state
    do_reset();
    chk("rst_req", req4, 0);
    chk("rst_wr", wr4, 0);
    chk("rst_size", sz4, 2);
    chk("rst_addr", ad4, 0);
    chk("rst_wdata", wd4, 0);
    chk("rst_rdata", r4, 0);
    chk("rst_stall_lo", st4, 0);
    cpu_en = 1'b1; #1;
    chk("rst_stall_follows_en", st4, 1);

    // 4-word read, separate addr_ok / data_ok cycles
    do_reset();
    cpu_en = 1'b1; cpu_addr = 32'h1FC0_0018;
    tick();
    chk("rd_req0", req4, 1);
    chk("rd_addr0", ad4, 32'h1FC0_0010);
    chk("rd_wr0", wr4, 0);
    chk("rd_size0", sz4, 2);
    for (int i = 0; i < 4; i++) begin
      addr_ok = 1'b1; tick(); addr_ok = 1'b0;
      chk("rd_req_drop", req4, 0);
      chk("rd_stall_mid", st4, 1);
      data_ok = 1'b1; rdata = words[i]; tick(); data_ok = 1'b0;
      if (i < 3) begin
        chk("rd_req_next", req4, 1);
        chk("rd_addr_next", ad4, 32'h1FC0_0010 + 32'(4 * (i + 1)));
      end
    end
    chk("rd_stall_done", st4, 0);
    chk("rd_line", r4, {words[3], words[2], words[1], words[0]});

    // table: 1-word data-port writes
    for (int v = 0; v < 7; v++) begin
      do_reset();
      cpu_en = 1'b1; cpu_wen = tbl[v].wen; cpu_addr = tbl[v].a; cpu_wdata = tbl[v].wd;
      tick();
      chk("wr_req", req1, 1);
      chk("wr_wr", wr1, 1);
      chk("wr_size", sz1, tbl[v].sz);
      chk("wr_addr", ad1, tbl[v].ea);
      chk("wr_wdata", wd1, tbl[v].wd);
      addr_ok = 1'b1; tick(); addr_ok = 1'b0;
      data_ok = 1'b1; rdata = 32'hDEAD_BEEF; tick(); data_ok = 1'b0;
      chk("wr_stall_done", st1, 0);
      chk("wr_rdata_untouched", r1, 0);
    end

    // same-cycle addr_ok/data_ok, then all_stall hold
    do_reset();
    cpu_en = 1'b1; cpu_addr = 32'h1FC0_0018; addr_ok = 1'b1; data_ok = 1'b1;
    tick();
    chk("fast_req", req4, 1);
    for (int i = 0; i < 4; i++) begin
      rdata = words[i];
      if (i == 3) all_stall = 1'b1;
      tick();
      if (i < 3) chk("fast_stall_mid", st4, 1);
    end
    addr_ok = 1'b0; data_ok = 1'b0;
    chk("fast_done_5cyc", st4, 0);
    chk("fast_line", r4, {words[3], words[2], words[1], words[0]});
    for (int k = 0; k < 6; k++) begin
      rdata = 32'h0F0F_0000 ^ 32'(k); data_ok = k[0];
      tick();
      chk("hold_line", r4, {words[3], words[2], words[1], words[0]});
      chk("hold_noreq", req4, 0);
      chk("hold_stall", st4, 0);
    end
    data_ok = 1'b0; all_stall = 1'b0;
    tick();
    chk("hold_idle_stall", st4, 1);
    chk("hold_idle_req", req4, 0);
    tick();
    chk("hold_restart_req", req4, 1);
    chk("hold_restart_addr", ad4, 32'h1FC0_0010);

    // reset during DATA at cnt=2, then a late data_ok
    do_reset();
    cpu_en = 1'b1; cpu_addr = 32'h1FC0_0018;
    tick();
    for (int i = 0; i < 2; i++) begin
      addr_ok = 1'b1; tick(); addr_ok = 1'b0;
      data_ok = 1'b1; rdata = words[i]; tick(); data_ok = 1'b0;
    end
    chk("mid_addr_w2", ad4, 32'h1FC0_0018);
    addr_ok = 1'b1; tick(); addr_ok = 1'b0;
    rst = 1'b1; cpu_en = 1'b0; tick(); rst = 1'b0;
    data_ok = 1'b1; rdata = 32'h1234_5678; tick(); data_ok = 1'b0;
    chk("late_req", req4, 0);
    chk("late_line", r4, 0);
    chk("late_stall", st4, 0);
    cpu_en = 1'b1; tick();
    chk("late_restart_req", req4, 1);
    chk("late_restart_addr", ad4, 32'h1FC0_0010);

    // read-only instance treats cpu_wen=1111 as a block read
    do_reset();
    cpu_en = 1'b1; cpu_addr = 32'h1FC0_0018; cpu_wen = 4'b1111;
    tick();
    chk("ro_req", req0, 1);
    chk("ro_addr", ad0, 32'h1FC0_0010);
    chk("ro_size", sz0, 2);
    addr_ok = 1'b1; data_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rdata = words[i];
      chk("ro_wr", wr0, 0);
      tick();
    end
    addr_ok = 1'b0; data_ok = 1'b0;
    chk("ro_done", st0, 0);
    chk("ro_line", r0, {words[3], words[2], words[1], words[0]});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
